// File: rtl/rdr_pkg.sv
// Shared types and constants for the 1402 read-station row collector.
// Row indices follow the physical brush read order: the 9-row arrives first, the 12-row last.
package rdr_pkg;

    localparam int RDR_COLS = 80;
    localparam int RDR_ROWS = 12;

    localparam int ROW_9  = 0;
    localparam int ROW_8  = 1;
    localparam int ROW_7  = 2;
    localparam int ROW_6  = 3;
    localparam int ROW_5  = 4;
    localparam int ROW_4  = 5;
    localparam int ROW_3  = 6;
    localparam int ROW_2  = 7;
    localparam int ROW_1  = 8;
    localparam int ROW_0  = 9;
    localparam int ROW_11 = 10;
    localparam int ROW_12 = 11;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } rdr_state_t;

    function automatic logic [6:0] popcount_cols(input logic [RDR_COLS-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < RDR_COLS; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/read_row_collector_if.sv
// Column stream from the row collector to the CPU side (valid/ready handshake).
interface read_row_collector_if;
    logic        col_valid;
    logic        col_ready;
    logic [6:0]  col_idx;
    logic [11:0] col_code;

    modport master (output col_valid, output col_idx, output col_code, input col_ready);
    modport slave  (input col_valid, input col_idx, input col_code, output col_ready);
endinterface

// File: rtl/rdr_edge_det.sv
// Registers the row strobe and card-cycle gate and produces single-cycle edge events.
module rdr_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sccb,
    input  logic cycle_gate,
    output logic sccb_rise,
    output logic gate_rise,
    output logic gate_fall
);
    logic sccb_q;
    logic gate_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sccb_q <= 1'b0;
            gate_q <= 1'b0;
        end else begin
            sccb_q <= sccb;
            gate_q <= cycle_gate;
        end
    end

    assign sccb_rise = sccb && !sccb_q;
    assign gate_rise = cycle_gate && !gate_q;
    assign gate_fall = !cycle_gate && gate_q;
endmodule

// File: rtl/read_row_collector.sv
// Collects twelve brush row planes per card and streams them out as 80 column punch codes.
// Optional feature: define CARD_HOLECOUNT_EN to add the card_holes output.
module read_row_collector
    import rdr_pkg::*;
#(
    parameter int COLS = RDR_COLS,
    parameter int ROWS = RDR_ROWS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sccb,
    input  logic                     cycle_gate,
    input  logic [COLS-1:0]          brushes,
    read_row_collector_if.master     col,
    output logic                     card_done,
    output logic                     err_short,
    output logic                     err_overrun
`ifdef CARD_HOLECOUNT_EN
    ,
    output logic [9:0]               card_holes
`endif
);
    rdr_state_t state, next_state;

    logic [3:0]                 row_cnt;
    logic [ROWS-1:0][COLS-1:0]  planes;
    logic [6:0]                 idx;
    logic [11:0]                code;
    logic sccb_rise, gate_rise, gate_fall;
    logic last_row, start_card, capture, drain_valid;

    rdr_edge_det u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .sccb       (sccb),
        .cycle_gate (cycle_gate),
        .sccb_rise  (sccb_rise),
        .gate_rise  (gate_rise),
        .gate_fall  (gate_fall)
    );

    assign last_row = (row_cnt == 4'(ROW_12));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // The 12th row wins over a simultaneous gate fall so a just-complete card is never flagged short.
    always_comb begin
        next_state  = state;
        start_card  = 1'b0;
        capture     = 1'b0;
        err_short   = 1'b0;
        card_done   = 1'b0;
        drain_valid = 1'b0;
        case (state)
            IDLE: begin
                if (gate_rise) begin
                    start_card = 1'b1;
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (sccb_rise && last_row) begin
                    capture    = 1'b1;
                    next_state = DRAIN;
                end else if (gate_fall) begin
                    err_short  = 1'b1;
                    next_state = IDLE;
                end else if (sccb_rise) begin
                    capture = 1'b1;
                end
            end
            DRAIN: begin
                drain_valid = 1'b1;
                if (col.col_ready && idx == 7'(COLS-1)) begin
                    card_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt     <= '0;
            planes      <= '0;
            idx         <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (start_card || err_short) begin
                row_cnt <= '0;
                planes  <= '0;
            end else if (capture) begin
                planes[row_cnt] <= brushes;
                row_cnt         <= row_cnt + 4'd1;
            end
            if (start_card || card_done) begin
                idx <= '0;
            end else if (drain_valid && col.col_ready) begin
                idx <= idx + 7'd1;
            end
            if (state == DRAIN && gate_rise) begin
                err_overrun <= 1'b1;
            end
        end
    end

`ifdef CARD_HOLECOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          card_holes <= '0;
        else if (start_card) card_holes <= '0;
        else if (capture)    card_holes <= card_holes + 10'(popcount_cols(brushes));
    end
`endif

    always_comb begin
        code = '0;
        for (int r = 0; r < ROWS; r++) begin
            code[r] = planes[r][idx];
        end
    end

    assign col.col_valid = drain_valid;
    assign col.col_idx   = idx;
    assign col.col_code  = code;
endmodule

// File: tb/tb_read_row_collector.sv
// Randomized self-checking bench for read_row_collector against a card-level scoreboard.
// Build with CARD_HOLECOUNT_EN defined to also exercise the hole counter.
module tb_read_row_collector;

    typedef struct {
        logic [6:0]  idx;
        logic [11:0] code;
    } col_t;

    logic        clk;
    logic        rst_n;
    logic        sccb;
    logic        cycle_gate;
    logic [79:0] brushes;
    logic        card_done;
    logic        err_short;
    logic        err_overrun;
`ifdef CARD_HOLECOUNT_EN
    logic [9:0]  card_holes;
    int          exp_holes;
`endif

    read_row_collector_if bus ();

    read_row_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sccb        (sccb),
        .cycle_gate  (cycle_gate),
        .brushes     (brushes),
        .col         (bus.master),
        .card_done   (card_done),
        .err_short   (err_short),
        .err_overrun (err_overrun)
`ifdef CARD_HOLECOUNT_EN
        ,
        .card_holes  (card_holes)
`endif
    );

    int          checks;
    int          errors;
    int          done_seen;
    int          done_exp;
    int          short_seen;
    int          short_exp;
    int          ready_mode;
    logic [79:0] card_rows [12];
    col_t        exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [79:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    function automatic logic [11:0] modelCode(input int c);
        logic [11:0] v;
        for (int r = 0; r < 12; r++) v[r] = card_rows[r][c];
        return v;
    endfunction

    task automatic expectCard();
        col_t e;
        for (int c = 0; c < 80; c++) begin
            e.idx  = 7'(c);
            e.code = modelCode(c);
            exp_q.push_back(e);
        end
        done_exp++;
`ifdef CARD_HOLECOUNT_EN
        exp_holes = 0;
        for (int r = 0; r < 12; r++) exp_holes += $countones(card_rows[r]);
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Brushes change during the second strobe cycle so only the rise-cycle value may be captured.
    task automatic strobe(input logic [79:0] d);
        brushes = d;
        sccb    = 1'b1;
        tick(1);
        brushes = rand80();
        tick(1);
        sccb    = 1'b0;
        tick(3);
    endtask

    task automatic applyStimulus(input int nrows, input bit full);
        if (full) expectCard();
        cycle_gate = 1'b1;
        tick(2);
        for (int r = 0; r < nrows; r++) strobe(card_rows[r]);
        cycle_gate = 1'b0;
        tick(2);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        checkOutput("drain_remaining", exp_q.size(), 0);
        tick(3);
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.col_ready = 1'b0;
            1:       bus.col_ready = 1'b1;
            default: bus.col_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        col_t e;
        if (rst_n) begin
            if (bus.col_valid && bus.col_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_col", 32'(bus.col_idx) + 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("col_idx", 32'(bus.col_idx), 32'(e.idx));
                    checkOutput("col_code", 32'(bus.col_code), 32'(e.code));
                    checkOutput("card_done_at_col", 32'(card_done), 32'(e.idx == 7'd79));
`ifdef CARD_HOLECOUNT_EN
                    if (e.idx == 7'd79) checkOutput("card_holes", 32'(card_holes), exp_holes);
`endif
                end
            end
            if (card_done) done_seen++;
            if (err_short) short_seen++;
        end
    end

    initial begin
        int n;
        logic [11:0] code5;
        checks = 0; errors = 0;
        done_seen = 0; done_exp = 0; short_seen = 0; short_exp = 0;
        ready_mode = 0;
        rst_n = 1'b0; sccb = 1'b0; cycle_gate = 1'b0; brushes = '0;
        tick(3);
        checkOutput("rst_valid", 32'(bus.col_valid), 0);
        checkOutput("rst_idx", 32'(bus.col_idx), 0);
        checkOutput("rst_code", 32'(bus.col_code), 0);
        checkOutput("rst_done", 32'(card_done), 0);
        checkOutput("rst_short", 32'(err_short), 0);
        checkOutput("rst_overrun", 32'(err_overrun), 0);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] full card, diagonal pattern");
        ready_mode = 1;
        for (int r = 0; r < 12; r++) card_rows[r] = 80'(1) << r;
        applyStimulus(12, 1'b1);
        waitDrain();
        checkOutput("diag_done_cnt", done_seen, done_exp);

        $display("[TB] short card");
        for (int r = 0; r < 12; r++) card_rows[r] = rand80();
        short_exp++;
        applyStimulus(7, 1'b0);
        tick(20);
        checkOutput("short_cnt", short_seen, short_exp);
        checkOutput("short_no_valid", 32'(bus.col_valid), 0);
        checkOutput("short_done_cnt", done_seen, done_exp);

        $display("[TB] random cards, random ready");
        ready_mode = 2;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 12; r++) card_rows[r] = rand80();
            applyStimulus(12, 1'b1);
            waitDrain();
        end
        checkOutput("rand_done_cnt", done_seen, done_exp);
        checkOutput("rand_overrun", 32'(err_overrun), 0);

        $display("[TB] backpressure at column 5");
        ready_mode = 0;
        for (int r = 0; r < 12; r++) card_rows[r] = rand80();
        code5 = modelCode(5);
        applyStimulus(12, 1'b1);
        ready_mode = 1;
        n = 0;
        while (bus.col_idx != 7'd5 && n < 200) begin
            tick(1);
            n++;
        end
        ready_mode = 0;
        checkOutput("bp_reach_idx5", 32'(bus.col_idx), 5);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checkOutput("bp_idx", 32'(bus.col_idx), 5);
            checkOutput("bp_code", 32'(bus.col_code), 32'(code5));
        end
        ready_mode = 2;
        waitDrain();
        checkOutput("bp_done_cnt", done_seen, done_exp);

        $display("[TB] overrun during drain");
        ready_mode = 0;
        for (int r = 0; r < 12; r++) card_rows[r] = rand80();
        applyStimulus(12, 1'b1);
        ready_mode = 1;
        n = 0;
        while (bus.col_idx != 7'd40 && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("ov_reach_idx40", 32'(bus.col_idx), 40);
        cycle_gate = 1'b1;
        tick(2);
        checkOutput("ov_flag", 32'(err_overrun), 1);
        for (int r = 0; r < 12; r++) strobe(rand80());
        cycle_gate = 1'b0;
        tick(2);
        waitDrain();
        tick(20);
        checkOutput("ov_no_extra", exp_q.size(), 0);
        checkOutput("ov_done_cnt", done_seen, done_exp);
        checkOutput("ov_sticky", 32'(err_overrun), 1);

        $display("[TB] reset during strobe 6");
        for (int r = 0; r < 12; r++) card_rows[r] = rand80();
        cycle_gate = 1'b1;
        tick(2);
        for (int r = 0; r < 6; r++) strobe(card_rows[r]);
        brushes = card_rows[6];
        sccb = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(bus.col_valid), 0);
        checkOutput("mid_rst_idx", 32'(bus.col_idx), 0);
        checkOutput("mid_rst_done", 32'(card_done), 0);
        checkOutput("mid_rst_short", 32'(err_short), 0);
        checkOutput("mid_rst_overrun", 32'(err_overrun), 0);
        tick(2);
        sccb = 1'b0;
        cycle_gate = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        ready_mode = 2;
        for (int r = 0; r < 12; r++) card_rows[r] = rand80();
        applyStimulus(12, 1'b1);
        waitDrain();
        checkOutput("post_rst_done_cnt", done_seen, done_exp);
        checkOutput("post_rst_short_cnt", short_seen, short_exp);

`ifdef CARD_HOLECOUNT_EN
        $display("[TB] all holes punched");
        for (int r = 0; r < 12; r++) card_rows[r] = '1;
        applyStimulus(12, 1'b1);
        waitDrain();
        checkOutput("holes_full", 32'(card_holes), 960);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_row_collector.md
# read_row_collector

Downstream consumer of the clutch/cam assembly's row strobe for the 1402 read station. Counts the twelve `sccb` row pulses of each clutched-shaft revolution and samples the 80 read-brush contacts on each pulse. Transposes the row planes into 80 twelve-bit column punch codes and streams them to the CPU-side interface over a valid/ready handshake. Flags short cards and overruns.

## Interface
Parameters:
- `COLS`, 80: card columns; brush vector width and column count.
- `ROWS`, 12: row strobes per card; fixed by the cam timing, not user-tunable.

Ports:
- `clk`  in  1: simulation tick clock, one per shaft degree.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sccb`  in  1: row strobe from the clutch cam assembly; 2-cycle-wide pulses at clutched-shaft angles 12, 30, …, 210.
- `cycle_gate`  in  1: high while a card read cycle is in progress; driven from the clutch latch.
- `brushes`  in  COLS: read-brush contacts; bit c = hole sensed in column c.
- `col_valid`  out  1: column code available.
- `col_ready`  in  1: consumer accepts the column.
- `col_idx`  out  7: column number, 0..79.
- `col_code`  out  12: punch code. Bit 0 = first row read (9-row), through bit 11 = 12-row. Order is 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 11, 12.
- `card_done`  out  1: one-cycle pulse when column 79 is accepted.
- `err_short`  out  1: one-cycle pulse when a card is aborted before all 12 rows are captured.
- `err_overrun`  out  1: sticky; set when a new card starts during drain. Cleared only by reset.

## Operation
- States:
  - IDLE: waiting for a card cycle.
  - COLLECT: capturing row planes.
  - DRAIN: streaming columns out.
- Strobe detection: `sccb` is registered into `sccb_q`. A row event occurs on the cycle where `sccb && !sccb_q`. The 2-cycle pulse width yields exactly one event.
- IDLE → COLLECT: on the rising edge of `cycle_gate`. The row counter clears to 0 and the column buffer clears.
- COLLECT, on each row event:
  - For every column c, `buffer[c][row]` is loaded from `brushes[c]` as sampled in the event cycle.
  - The row counter increments.
- COLLECT → DRAIN: after row event 11 (the 12th).
- COLLECT → IDLE on `cycle_gate` falling with fewer than 12 rows captured. `err_short` pulses and the buffer is discarded. No columns are emitted.
- DRAIN:
  - `col_valid` is high and `col_idx` starts at 0.
  - On each `col_valid && col_ready`, `col_idx` increments.
  - Accepting column 79 pulses `card_done` and returns to IDLE.
- A `cycle_gate` rising edge while in DRAIN sets `err_overrun`. That card is ignored completely and the drain continues undisturbed.
- Row events seen in IDLE or DRAIN are ignored.
- A 13th row event in COLLECT is impossible, because the transition to DRAIN occurs on the 12th event.
- Blank column: `col_code` = 0 and it is still emitted.

## Timing
- Reset values:
  - State = IDLE; row counter = 0; `col_idx` = 0.
  - `col_valid`, `card_done`, `err_short` and `err_overrun` = 0.
  - Buffer = 0.
- Row sampling has one cycle of latency from the `sccb` rise, because detection uses `sccb_q`.
- `col_valid` rises on the cycle after the 12th row event.
- `col_idx` and `col_code` are stable while `col_valid && !col_ready`.
- Minimum drain is 80 cycles with `col_ready` held high. This fits before the next card's first strobe: drain starts at about 211°, the next first strobe is at 372°.
- `cycle_gate` falling in the same cycle as the 12th row event: the row is captured and the block enters DRAIN. No `err_short` is raised.
- Reset asserted mid-card or mid-drain: outputs return to reset values immediately. Nothing is emitted. `err_overrun` is cleared.

## Configuration
- `CARD_HOLECOUNT_EN`: when defined, adds output `card_holes [9:0]`.
  - It counts set bits accumulated over all row events of the card. The maximum is 960.
  - The value is valid on the `card_done` pulse and held until the next card starts. Reset value is 0.
- When the macro is undefined, the port and counter are absent and all other behaviour is identical.

## Structure
- Shared package `rdr_pkg`:
  - State enum `rdr_state_t` (IDLE, COLLECT, DRAIN).
  - `RDR_COLS` = 80 and `RDR_ROWS` = 12.
  - Row-index constants naming the 9…12 read order.
- One sub-module, `rdr_edge_det`: registers `sccb` and `cycle_gate` and emits single-cycle rise/fall events. It is also reused by upstream feed control.

## Test plan
- **Full card:** columns 0..11 each punched in a single row (col k in row k); drive 12 strobes, `col_ready` = 1 → 80 columns. `col_code[k]` = 1<<k for k<12, 0 otherwise. `card_done` pulses once.
- **Short card:** drop `cycle_gate` after 7 strobes → `err_short` pulses once, no `col_valid`, state returns to IDLE.
- **Backpressure:** hold `col_ready` = 0 for 20 cycles at `col_idx` = 5 → `col_idx` and `col_code` are held, with no skipped or duplicated columns.
- **Overrun:** raise `cycle_gate` while `col_idx` = 40 in drain → `err_overrun` = 1. The remaining columns 40..79 are emitted intact and no second card is collected.
- **Reset:** assert `rst_n` low during strobe 6 → all outputs 0 at once. The next full card reads correctly.
- **Hole count** (with `CARD_HOLECOUNT_EN`): all 960 brush bits set on every strobe → `card_holes` = 960 at `card_done`.
